uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_uart_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// UART memory loader: receives W/R commands over 8N1 serial, masters a byte bus
// while holding the CPU, and returns read data or an ACK byte over TXD.
module uart_loader #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        RXD,
  output logic        TXD,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        frame_err
);

  localparam int unsigned Div  = CLK_HZ / BAUD;
  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] DivM1  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(Div / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [3:0] {
    StCmd, StAh, StAl, StLen, StWdata, StWbus, StRbus, StRsend, StAck
  } p_state_e;

  // Synchronizer plus previous value for falling-edge detection; idle high
  logic rxd_s1, rxd_s2, rxd_prev;

  // Two-flop RXD synchronizer and edge history
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= RXD;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_err_q, rx_err_d;

  // Receiver state register
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Receiver next state: half-bit to mid start, then one sample per bit period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    if (rx_state_q != RxIdle && rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          if (rxd_prev && !rxd_s2) begin
            rx_state_d = RxStart;
            rx_cnt_d   = HalfM1;
          end
        end
        RxStart: begin
          // High at mid start bit is a glitch: drop silently
          if (rxd_s2) begin
            rx_state_d = RxIdle;
          end else begin
            rx_state_d = RxData;
            rx_cnt_d   = DivM1;
            rx_bit_d   = '0;
          end
        end
        RxData: begin
          rx_shift_d = {rxd_s2, rx_shift_q[7:1]};
          rx_cnt_d   = DivM1;
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
        RxStop: begin
          rx_valid_d = rxd_s2;
          rx_err_d   = !rxd_s2;
          rx_state_d = RxIdle;
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  logic            tx_load;
  logic [7:0]      tx_byte;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bits_q, tx_bits_d;
  logic            tx_busy_q, tx_busy_d;
  logic            tx_done_q, tx_done_d;

  // Transmitter state register
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bits_q  <= tx_bits_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Transmitter next state: shift {stop, data, start} out LSB first
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    if (tx_load) begin
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_cnt_d   = DivM1;
      tx_bits_d  = 4'd9;
      tx_busy_d  = 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_d = tx_cnt_q - 1'b1;
      end else if (tx_bits_q == '0) begin
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
      end else begin
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bits_d  = tx_bits_q - 1'b1;
        tx_cnt_d   = DivM1;
      end
    end
  end

  assign TXD = tx_busy_q ? tx_shift_q[0] : 1'b1;

  p_state_e    p_state_q, p_state_d;
  logic [15:0] addr_q, addr_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  skid_q, skid_d;
  logic        skid_full_q, skid_full_d;
  logic        is_wr_q, is_wr_d;
  logic        abort_q, abort_d;
  logic        skid_ovf;

  // Command parser state register
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q   <= StCmd;
      addr_q      <= '0;
      rem_q       <= '0;
      wdata_q     <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      is_wr_q     <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      p_state_q   <= p_state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wdata_q     <= wdata_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      is_wr_q     <= is_wr_d;
      abort_q     <= abort_d;
    end
  end

  // Command parser next state, bus sequencing and transmit requests
  always_comb begin
    p_state_d   = p_state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    wdata_d     = wdata_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    is_wr_d     = is_wr_q;
    abort_d     = abort_q;
    tx_load     = 1'b0;
    tx_byte     = 8'h06;
    skid_ovf    = 1'b0;
    unique case (p_state_q)
      StCmd: begin
        if (rx_valid_q && (rx_shift_q == 8'h57 || rx_shift_q == 8'h52)) begin
          is_wr_d   = (rx_shift_q == 8'h57);
          p_state_d = StAh;
        end
      end
      StAh, StAl, StLen, StWdata: begin
        if (rx_err_q) begin
          p_state_d = StCmd;
        end else if (rx_valid_q) begin
          unique case (p_state_q)
            StAh: begin
              addr_d[15:8] = rx_shift_q;
              p_state_d    = StAl;
            end
            StAl: begin
              addr_d[7:0] = rx_shift_q;
              p_state_d   = StLen;
            end
            StLen: begin
              rem_d     = {rx_shift_q == 8'h00, rx_shift_q};
              p_state_d = is_wr_q ? StWdata : StRbus;
            end
            default: begin
              wdata_d   = rx_shift_q;
              p_state_d = StWbus;
            end
          endcase
        end
      end
      StWbus: begin
        // A framing error here waits for the in-flight write to finish
        if (rx_err_q) abort_d = 1'b1;
        if (mem_ack) begin
          addr_d = addr_q + 16'd1;
          rem_d  = rem_q - 9'd1;
          if (abort_q || rx_err_q) begin
            p_state_d   = StCmd;
            abort_d     = 1'b0;
            skid_full_d = 1'b0;
          end else if (rem_q == 9'd1) begin
            p_state_d   = StAck;
            tx_load     = 1'b1;
            skid_full_d = 1'b0;
          end else if (skid_full_q) begin
            wdata_d     = skid_q;
            skid_full_d = rx_valid_q;
            if (rx_valid_q) skid_d = rx_shift_q;
          end else if (rx_valid_q) begin
            wdata_d = rx_shift_q;
          end else begin
            p_state_d = StWdata;
          end
        end else if (rx_valid_q) begin
          skid_d      = rx_shift_q;
          skid_full_d = 1'b1;
          skid_ovf    = skid_full_q;
        end
      end
      StRbus: begin
        if (rx_err_q) abort_d = 1'b1;
        if (mem_ack) begin
          if (abort_q || rx_err_q) begin
            p_state_d = StCmd;
            abort_d   = 1'b0;
          end else begin
            tx_load   = 1'b1;
            tx_byte   = mem_rdata;
            p_state_d = StRsend;
          end
        end
      end
      StRsend: begin
        if (rx_err_q) begin
          p_state_d = StCmd;
        end else if (tx_done_q) begin
          addr_d    = addr_q + 16'd1;
          rem_d     = rem_q - 9'd1;
          p_state_d = (rem_q == 9'd1) ? StCmd : StRbus;
        end
      end
      StAck: begin
        if (rx_err_q || tx_done_q) p_state_d = StCmd;
      end
      default: p_state_d = StCmd;
    endcase
  end

  assign mem_req   = (p_state_q == StWbus) || (p_state_q == StRbus);
  assign mem_we    = (p_state_q == StWbus);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = (p_state_q != StCmd);
  assign frame_err = rx_err_q || skid_ovf;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial command stimulus, bus responder,
// serial capture of TXD and hand-computed expectations.
module tb_uart_loader;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;

  logic        clk_50 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        RXD    = 1'b1;
  logic        TXD;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        cpu_hold, frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .RXD      (RXD),
    .TXD      (TXD),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .cpu_hold (cpu_hold),
    .frame_err(frame_err)
  );

  always #5 clk_50 = ~clk_50;

  // Fixed read image: 0xFFFF=0x11, 0x0000=0x22, elsewhere low byte ^ 0x5A
  assign mem_rdata = (mem_addr == 16'hFFFF) ? 8'h11 :
                     (mem_addr == 16'h0000) ? 8'h22 : (mem_addr[7:0] ^ 8'h5A);

  // Bus responder with programmable ack latency, logging every access
  int          ack_dly  = 0;
  int          wait_cnt = 0;
  int          wr_n     = 0;
  int          rd_n     = 0;
  logic [15:0] wr_addr [0:511];
  logic [7:0]  wr_data [0:511];
  logic [15:0] rd_addr [0:15];

  always @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (wait_cnt >= ack_dly) begin
          mem_ack  <= 1'b1;
          wait_cnt <= 0;
          if (mem_we) begin
            if (wr_n < 512) begin
              wr_addr[wr_n] <= mem_addr;
              wr_data[wr_n] <= mem_wdata;
            end
            wr_n <= wr_n + 1;
          end else begin
            if (rd_n < 16) rd_addr[rd_n] <= mem_addr;
            rd_n <= rd_n + 1;
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // Bus protocol monitor and frame_err pulse counter
  int          viol = 0;
  int          fe_n = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;

  always @(posedge clk_50) begin
    viol <= viol + ((mem_req && !cpu_hold) ? 1 : 0) +
            ((mem_req && prev_req && !prev_ack &&
              (mem_addr != prev_addr || mem_we != prev_we ||
               (mem_we && mem_wdata != prev_wdata))) ? 1 : 0);
    if (frame_err) fe_n <= fe_n + 1;
    prev_req   <= mem_req;
    prev_ack   <= mem_ack;
    prev_we    <= mem_we;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  // Serial capture of TXD, sampled mid-bit on the falling clock edge
  logic [7:0] tx_bytes [0:15];
  int         tx_n = 0;

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge TXD);
      repeat (DIV / 2) @(negedge clk_50);
      if (TXD == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk_50);
          b[i] = TXD;
        end
        repeat (DIV) @(negedge clk_50);
        if (tx_n < 16) tx_bytes[tx_n] = b;
        tx_n++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8N1 frame plus one idle bit; called on a falling clock edge
  task automatic send_byte(input logic [7:0] b, input logic stop);
    RXD = 1'b0;
    repeat (DIV) @(negedge clk_50);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (DIV) @(negedge clk_50);
    end
    RXD = stop;
    repeat (DIV) @(negedge clk_50);
    RXD = 1'b1;
    repeat (DIV) @(negedge clk_50);
  endtask

  task automatic wait_hold_low(input int max_cyc, input string tag);
    int i = 0;
    while (cpu_hold && i < max_cyc) begin
      @(negedge clk_50);
      i++;
    end
    check_eq(tag, 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    int wb, tb, fb, bad;

    // Reset values
    repeat (3) @(negedge clk_50);
    check_eq("rst_txd", 32'(TXD), 32'd1);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_hold", 32'(cpu_hold), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50);

    // Two-byte write at 0x1234 then ACK
    wb = wr_n; tb = tx_n;
    send_byte(8'h57, 1'b1);
    check_eq("w_hold_set", 32'(cpu_hold), 32'd1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    wait_hold_low(400, "w_hold_clr");
    check_eq("w_count", 32'(wr_n - wb), 32'd2);
    check_eq("w_addr0", 32'(wr_addr[wb]), 32'h1234);
    check_eq("w_data0", 32'(wr_data[wb]), 32'hAA);
    check_eq("w_addr1", 32'(wr_addr[wb+1]), 32'h1235);
    check_eq("w_data1", 32'(wr_data[wb+1]), 32'hBB);
    check_eq("w_txcnt", 32'(tx_n - tb), 32'd1);
    check_eq("w_ack", 32'(tx_bytes[tb]), 32'h06);

    // Two-byte read wrapping 0xFFFF -> 0x0000
    tb = tx_n;
    send_byte(8'h52, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_hold_low(600, "r_hold_clr");
    check_eq("r_count", 32'(rd_n), 32'd2);
    check_eq("r_addr0", 32'(rd_addr[0]), 32'hFFFF);
    check_eq("r_addr1", 32'(rd_addr[1]), 32'h0000);
    check_eq("r_txcnt", 32'(tx_n - tb), 32'd2);
    check_eq("r_tx0", 32'(tx_bytes[tb]), 32'h11);
    check_eq("r_tx1", 32'(tx_bytes[tb+1]), 32'h22);

    // len=0 means 256 bytes, ack delayed 3 clocks
    ack_dly = 3;
    wb = wr_n; tb = tx_n;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'hC3, 1'b1);
    wait_hold_low(400, "l_hold_clr");
    check_eq("l_count", 32'(wr_n - wb), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_addr[wb+i] != 16'(16'h0010 + i) || wr_data[wb+i] != (8'(i) ^ 8'hC3)) bad++;
    end
    check_eq("l_bad_entries", 32'(bad), 32'd0);
    check_eq("l_last_addr", 32'(wr_addr[wb+255]), 32'h010F);
    check_eq("l_ack", 32'(tx_bytes[tb]), 32'h06);

    // Bad stop bit on 'W', then an unknown command byte
    ack_dly = 0;
    fb = fe_n; wb = wr_n;
    send_byte(8'h57, 1'b0);
    check_eq("fe_pulse", 32'(fe_n - fb), 32'd1);
    check_eq("fe_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'h41, 1'b1);
    check_eq("ign_hold", 32'(cpu_hold), 32'd0);
    check_eq("ign_fe", 32'(fe_n - fb), 32'd1);

    // Short low glitch on RXD
    fb = fe_n;
    RXD = 1'b0;
    repeat (3) @(negedge clk_50);
    RXD = 1'b1;
    repeat (4 * DIV) @(negedge clk_50);
    check_eq("gl_fe", 32'(fe_n - fb), 32'd0);
    check_eq("gl_hold", 32'(cpu_hold), 32'd0);
    check_eq("gl_nowrite", 32'(wr_n - wb), 32'd0);

    // Reset asserted while a write waits for its ack
    ack_dly = 50;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hAA, 1'b1);
    begin
      int i = 0;
      while (!mem_req && i < 50) begin
        @(negedge clk_50);
        i++;
      end
    end
    check_eq("mr_req_pending", 32'(mem_req), 32'd1);
    wb = wr_n;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_req", 32'(mem_req), 32'd0);
    check_eq("mr_hold", 32'(cpu_hold), 32'd0);
    check_eq("mr_addr", 32'(mem_addr), 32'd0);
    check_eq("mr_we", 32'(mem_we), 32'd0);
    check_eq("mr_txd", 32'(TXD), 32'd1);
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    repeat (20 * DIV) @(negedge clk_50);
    check_eq("mr_after_req", 32'(mem_req), 32'd0);
    check_eq("mr_after_hold", 32'(cpu_hold), 32'd0);
    check_eq("mr_nowrite", 32'(wr_n - wb), 32'd0);

    check_eq("bus_protocol", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
